// File: rtl/dpd_lms_adapt.sv
// -----------------------------------------------------------------------------
// dpd_lms_adapt
//   Complex-LMS adaptation engine for the memory-3 / degree-5 DPD core.
//   Each accepted sample runs coeff[k] += mu * err * conj(yy[k]) for all 15
//   basis terms over one time-shared complex multiplier. The result is then
//   published to the core in a single commit cycle.
//
// Ports
//   clk       system clock, rising edge
//   reset_b   asynchronous active-low reset
//   enable    adaptation enable (gates acceptance of new samples only)
//   clear     synchronous reload of accumulators/coeff, aborts iteration
//   smp_stb   yy/err valid strobe
//   err_i/q   signed 20-bit error sample
//   mu_shift  step size exponent, mu = 2^-(PROD_SHIFT+mu_shift)
//   yy        15 complex basis terms from the DPD core
//   coeff     15 complex registered coefficients to the DPD core
//   busy      iteration in progress
//   done      one-cycle pulse coincident with a coeff update
//   overrun   sticky: strobe arrived while busy
//   iter_cnt  completed iteration counter (wraps)
// -----------------------------------------------------------------------------
package dpd_lms_pkg;
    typedef logic [19:0] coef_t;

    typedef struct packed {
        coef_t [14:0] i;
        coef_t [14:0] q;
    } intf_coef_3_5;
endpackage

module dpd_lms_adapt
    import dpd_lms_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int PROD_SHIFT = 8,
    parameter int UNITY      = 131072
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               enable,
    input  logic               clear,
    input  logic               smp_stb,
    input  logic signed [19:0] err_i,
    input  logic signed [19:0] err_q,
    input  logic [3:0]         mu_shift,
    input  intf_coef_3_5       yy,
    output intf_coef_3_5       coeff,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic [15:0]        iter_cnt
);

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    localparam logic [ACC_W-1:0] ACC_INIT0  = ACC_W'(UNITY) << (ACC_W - 20);
    localparam logic [19:0]      COEF_INIT0 = 20'(UNITY);
    // Saturation bounds held in the 43-bit sum domain (acc + 41-bit product).
    localparam logic signed [42:0] ACC_MAX = (43'sd1 <<< (ACC_W - 1)) - 43'sd1;
    localparam logic signed [42:0] ACC_MIN = -(43'sd1 <<< (ACC_W - 1));

    state_t             state;
    logic [3:0]         cnt;        // product-issue index during UPDATE
    intf_coef_3_5       yy_r;
    logic [19:0]        err_i_r, err_q_r;
    logic [3:0]         mu_r;

    logic               prod_vld;
    logic [3:0]         prod_k;
    logic [40:0]        prod_re, prod_im;

    logic [ACC_W-1:0]   acc_i [15];
    logic [ACC_W-1:0]   acc_q [15];

    // Product stage: err * conj(yy[k]), scaled by mu.
    logic [3:0]          k_sel;
    logic [19:0]         yi, yq;
    logic signed [40:0]  ei_x, eq_x, yi_x, yq_x;
    logic signed [40:0]  re_full, im_full, re_scaled, im_scaled;
    logic [4:0]          shamt;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred; here each assignment is unconditional.
    always_comb begin
        k_sel     = (cnt > 4'd14) ? 4'd14 : cnt;
        yi        = yy_r.i[k_sel];
        yq        = yy_r.q[k_sel];
        ei_x      = {{21{err_i_r[19]}}, err_i_r};
        eq_x      = {{21{err_q_r[19]}}, err_q_r};
        yi_x      = {{21{yi[19]}}, yi};
        yq_x      = {{21{yq[19]}}, yq};
        re_full   = ei_x * yi_x + eq_x * yq_x;
        im_full   = eq_x * yi_x - ei_x * yq_x;
        shamt     = 5'(PROD_SHIFT) + {1'b0, mu_r};
        re_scaled = re_full >>> shamt;
        im_scaled = im_full >>> shamt;
    end

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [40:0]      b);
        logic signed [42:0] s;
        s = $signed({{(43 - ACC_W){a[ACC_W-1]}}, a}) + $signed({{2{b[40]}}, b});
        if (s > ACC_MAX)      sat_add = ACC_MAX[ACC_W-1:0];
        else if (s < ACC_MIN) sat_add = ACC_MIN[ACC_W-1:0];
        else                  sat_add = s[ACC_W-1:0];
    endfunction

    function automatic intf_coef_3_5 coeff_init();
        intf_coef_3_5 c;
        c      = '0;
        c.i[0] = COEF_INIT0;
        return c;
    endfunction

    assign busy = (state != IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            cnt      <= '0;
            yy_r     <= '0;
            err_i_r  <= '0;
            err_q_r  <= '0;
            mu_r     <= '0;
            prod_vld <= 1'b0;
            prod_k   <= '0;
            prod_re  <= '0;
            prod_im  <= '0;
            for (int k = 0; k < 15; k++) begin
                acc_i[k] <= (k == 0) ? ACC_INIT0 : '0;
                acc_q[k] <= '0;
            end
            coeff    <= coeff_init();
            done     <= 1'b0;
            overrun  <= 1'b0;
            iter_cnt <= '0;
        end else if (clear) begin
            // Sample on the same edge is dropped; overrun is reset, not set.
            state    <= IDLE;
            cnt      <= '0;
            prod_vld <= 1'b0;
            for (int k = 0; k < 15; k++) begin
                acc_i[k] <= (k == 0) ? ACC_INIT0 : '0;
                acc_q[k] <= '0;
            end
            coeff    <= coeff_init();
            done     <= 1'b0;
            overrun  <= 1'b0;
            iter_cnt <= '0;
        end else begin
            done <= 1'b0;

            if (smp_stb && state != IDLE)
                overrun <= 1'b1;

            // Accumulate stage trails the product stage by one cycle.
            if (prod_vld) begin
                acc_i[prod_k] <= sat_add(acc_i[prod_k], prod_re);
                acc_q[prod_k] <= sat_add(acc_q[prod_k], prod_im);
            end

            case (state)
                IDLE: begin
                    if (smp_stb && enable) begin
                        yy_r    <= yy;
                        err_i_r <= err_i;
                        err_q_r <= err_q;
                        mu_r    <= mu_shift;
                        cnt     <= '0;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    // cnt 0..14 issues products; cnt 15 only drains the last
                    // accumulate before moving to COMMIT.
                    prod_vld <= (cnt <= 4'd14);
                    prod_k   <= cnt;
                    prod_re  <= re_scaled;
                    prod_im  <= im_scaled;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= COMMIT;
                end
                COMMIT: begin
                    for (int k = 0; k < 15; k++) begin
                        coeff.i[k] <= acc_i[k][ACC_W-1 -: 20];
                        coeff.q[k] <= acc_q[k][ACC_W-1 -: 20];
                    end
                    done     <= 1'b1;
                    iter_cnt <= iter_cnt + 16'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpd_lms_adapt.sv
// -----------------------------------------------------------------------------
// tb_dpd_lms_adapt
//   Directed self-checking bench for dpd_lms_adapt. Inputs change and outputs
//   are sampled on the falling clock edge; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_dpd_lms_adapt;
    import dpd_lms_pkg::*;

    logic               clk;
    logic               reset_b;
    logic               enable;
    logic               clear;
    logic               smp_stb;
    logic signed [19:0] err_i;
    logic signed [19:0] err_q;
    logic [3:0]         mu_shift;
    intf_coef_3_5       yy;
    intf_coef_3_5       coeff;
    logic               busy;
    logic               done;
    logic               overrun;
    logic [15:0]        iter_cnt;

    int checks   = 0;
    int failures = 0;

    dpd_lms_adapt dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .enable   (enable),
        .clear    (clear),
        .smp_stb  (smp_stb),
        .err_i    (err_i),
        .err_q    (err_q),
        .mu_shift (mu_shift),
        .yy       (yy),
        .coeff    (coeff),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_coeff(input string tag, input intf_coef_3_5 exp);
        int bad_k;
        bad_k = -1;
        for (int k = 14; k >= 0; k--)
            if (coeff.i[k] !== exp.i[k] || coeff.q[k] !== exp.q[k]) bad_k = k;
        checks++;
        assert (coeff === exp)
        else begin
            failures++;
            $error("FAIL %s: first bad k=%0d observed i=%0h q=%0h expected i=%0h q=%0h",
                   tag, bad_k, coeff.i[bad_k], coeff.q[bad_k], exp.i[bad_k], exp.q[bad_k]);
        end
    endtask

    function automatic intf_coef_3_5 init_coeff();
        intf_coef_3_5 c;
        c      = '0;
        c.i[0] = 20'd131072;
        return c;
    endfunction

    // Strobe one sample (edge N) and wait for done. Returns with the bench at
    // the falling edge after the done edge; lat counts edges after N.
    task automatic run_iter(input logic [19:0] ei, input logic [19:0] eq,
                            input intf_coef_3_5 y, input logic [3:0] mu,
                            output int lat, output bit busy_ok);
        err_i    = ei;
        err_q    = eq;
        yy       = y;
        mu_shift = mu;
        smp_stb  = 1'b1;
        @(negedge clk);
        smp_stb  = 1'b0;
        lat      = -1;
        busy_ok  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                lat = c;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic watch_done(input int n, output int dones);
        dones = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    intf_coef_3_5 exp_c;
    intf_coef_3_5 y_v;
    int           lat;
    bit           busy_ok;
    int           dones;
    int           bad_lat;
    int           neg_seen;

    initial begin
        reset_b  = 1'b0;
        enable   = 1'b1;
        clear    = 1'b0;
        smp_stb  = 1'b0;
        err_i    = '0;
        err_q    = '0;
        mu_shift = '0;
        yy       = '0;

        // 1. Reset state
        repeat (3) @(negedge clk);
        exp_c = init_coeff();
        check_coeff("reset_coeff", exp_c);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_iter", 32'(iter_cnt), 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        check_coeff("post_reset_coeff", exp_c);

        // 2. Single term update: 1024*1024 >> 8 = 4096 -> coeff LSB = 1
        y_v = '0;
        y_v.i[3] = 20'd1024;
        run_iter(20'd1024, 20'd0, y_v, 4'd0, lat, busy_ok);
        check("t2_latency", 32'(lat), 32'd17);
        check("t2_busy_window", 32'(busy_ok), 32'd1);
        exp_c.i[3] = 20'd1;
        check_coeff("t2_coeff", exp_c);
        check("t2_iter", 32'(iter_cnt), 32'd1);
        @(negedge clk);
        check("t2_done_single", 32'(done), 32'd0);

        // 3. Conjugate handling
        pulse_clear();
        exp_c = init_coeff();
        y_v = '0;
        y_v.i[5] = 20'd1024;
        run_iter(20'd0, 20'd1024, y_v, 4'd0, lat, busy_ok);
        exp_c.q[5] = 20'd1;
        check("t3a_q5", 32'(coeff.q[5]), 32'h1);
        check_coeff("t3a_coeff", exp_c);
        pulse_clear();
        exp_c = init_coeff();
        y_v = '0;
        y_v.q[5] = 20'd1024;
        run_iter(20'd1024, 20'd0, y_v, 4'd0, lat, busy_ok);
        exp_c.q[5] = 20'hFFFFF;
        check("t3b_q5", 32'(coeff.q[5]), 32'hFFFFF);
        check("t3b_i5", 32'(coeff.i[5]), 32'h0);
        check_coeff("t3b_coeff", exp_c);

        // 4. Saturation over 5000 back-to-back iterations
        pulse_clear();
        y_v = '0;
        y_v.i[0] = 20'd524287;
        bad_lat  = 0;
        neg_seen = 0;
        for (int n = 0; n < 5000; n++) begin
            run_iter(20'd524287, 20'd0, y_v, 4'd0, lat, busy_ok);
            if (lat != 17) bad_lat++;
            if (coeff.i[0][19]) neg_seen++;
            if (lat < 0) break;
        end
        check("t4_latency_errors", 32'(bad_lat), 32'd0);
        check("t4_negative_seen", 32'(neg_seen), 32'd0);
        check("t4_i0_clamped", 32'(coeff.i[0]), 32'h7FFFF);
        check("t4_q0", 32'(coeff.q[0]), 32'h0);
        check("t4_iter", 32'(iter_cnt), 32'd5000);

        // Strobe with enable low in IDLE: ignored, overrun unaffected
        @(negedge clk);
        enable  = 1'b0;
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        check("en_low_busy", 32'(busy), 32'd0);
        watch_done(20, dones);
        check("en_low_dones", 32'(dones), 32'd0);
        check("en_low_overrun", 32'(overrun), 32'd0);
        check("en_low_iter", 32'(iter_cnt), 32'd5000);
        enable = 1'b1;

        // 5. Overrun: second strobe at N+5
        y_v = '0;
        y_v.i[3] = 20'd1024;
        err_i    = 20'd1024;
        err_q    = 20'd0;
        yy       = y_v;
        mu_shift = 4'd0;
        smp_stb  = 1'b1;
        @(negedge clk);
        smp_stb  = 1'b0;
        repeat (4) @(negedge clk);
        smp_stb  = 1'b1;
        @(negedge clk);
        smp_stb  = 1'b0;
        check("t5_overrun", 32'(overrun), 32'd1);
        watch_done(40, dones);
        check("t5_dones", 32'(dones), 32'd1);
        check("t5_iter", 32'(iter_cnt), 32'd5001);
        check("t5_i3", 32'(coeff.i[3]), 32'h1);
        check("t5_i0_kept", 32'(coeff.i[0]), 32'h7FFFF);
        pulse_clear();
        exp_c = init_coeff();
        check("t5_clear_overrun", 32'(overrun), 32'd0);
        check("t5_clear_iter", 32'(iter_cnt), 32'd0);
        check_coeff("t5_clear_coeff", exp_c);

        // clear and strobe together: clear wins, sample dropped
        clear   = 1'b1;
        smp_stb = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        smp_stb = 1'b0;
        check("clr_stb_busy", 32'(busy), 32'd0);
        watch_done(20, dones);
        check("clr_stb_dones", 32'(dones), 32'd0);
        check("clr_stb_overrun", 32'(overrun), 32'd0);

        // 6. Asynchronous reset mid-iteration
        run_iter(20'd1024, 20'd0, y_v, 4'd0, lat, busy_ok);
        exp_c.i[3] = 20'd1;
        check_coeff("t6_pre_coeff", exp_c);
        smp_stb = 1'b1;
        @(negedge clk);
        smp_stb = 1'b0;
        repeat (8) @(negedge clk);
        reset_b = 1'b0;
        #1;
        exp_c = init_coeff();
        check_coeff("t6_reset_coeff", exp_c);
        check("t6_reset_busy", 32'(busy), 32'd0);
        check("t6_reset_iter", 32'(iter_cnt), 32'd0);
        watch_done(3, dones);
        check("t6_reset_dones", 32'(dones), 32'd0);
        reset_b = 1'b1;
        @(negedge clk);
        run_iter(20'd1024, 20'd0, y_v, 4'd0, lat, busy_ok);
        check("t6_latency", 32'(lat), 32'd17);
        exp_c.i[3] = 20'd1;
        check_coeff("t6_post_coeff", exp_c);
        check("t6_post_iter", 32'(iter_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
